// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues a request-to-send,
// shifts one command byte plus odd parity and stop bit out on device clock edges, then checks the ack.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 1500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       done,
    output logic       nack,
    output logic       timeout
);

    localparam int CW = $clog2((INHIBIT_CYCLES > 16) ? INHIBIT_CYCLES : 16) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] REQ_LAST = CW'(15);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

    // Frame order after the start bit: D0..D7, odd parity, stop.
    function automatic logic frame_bit(input logic [7:0] d, input logic [3:0] idx);
        if (idx < 4'd8)
            return d[idx[2:0]];
        else if (idx == 4'd8)
            return odd_parity(d);
        else
            return 1'b1;
    endfunction

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [TW-1:0]   r_tcnt;
    logic [3:0]      r_bit_cnt;
    logic [7:0]      r_byte;
    logic            r_nack_pend;
    logic            r_tx_ready;
    logic            r_busy;
    logic            r_clk_oe;
    logic            r_data_oe;
    logic            r_done;
    logic            r_nack;
    logic            r_timeout;

    logic            r_clk_s1;
    logic            r_clk_s2;
    logic            r_clk_d;
    logic            r_data_s1;
    logic            r_data_s2;

    logic            w_fall;
    logic            w_in_xfer;
    logic            w_tmo;

    // Lines idle high, so synchronizers reset to 1 to avoid a phantom edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_s1  <= 1'b1;
            r_clk_s2  <= 1'b1;
            r_clk_d   <= 1'b1;
            r_data_s1 <= 1'b1;
            r_data_s2 <= 1'b1;
        end else begin
            r_clk_s1  <= ps2_clk_i;
            r_clk_s2  <= r_clk_s1;
            r_clk_d   <= r_clk_s2;
            r_data_s1 <= ps2_data_i;
            r_data_s2 <= r_data_s1;
        end
    end

    assign w_fall    = r_clk_d & ~r_clk_s2;
    assign w_in_xfer = (r_state == S_SEND) || (r_state == S_ACK) || (r_state == S_WAIT_IDLE);
    assign w_tmo     = w_in_xfer && (r_tcnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_tcnt      <= '0;
            r_bit_cnt   <= '0;
            r_byte      <= '0;
            r_nack_pend <= 1'b0;
            r_tx_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_clk_oe    <= 1'b0;
            r_data_oe   <= 1'b0;
            r_done      <= 1'b0;
            r_nack      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_tmo) begin
                r_clk_oe  <= 1'b0;
                r_data_oe <= 1'b0;
                r_done    <= 1'b1;
                r_timeout <= 1'b1;
                r_nack    <= 1'b0;
                r_state   <= S_IDLE;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        // tx_ready rises one cycle after done, so no byte is taken in the done cycle.
                        r_tx_ready <= 1'b1;
                        r_busy     <= 1'b0;
                        r_clk_oe   <= 1'b0;
                        r_data_oe  <= 1'b0;
                        if (tx_valid && r_tx_ready) begin
                            r_byte     <= tx_data;
                            r_tx_ready <= 1'b0;
                            r_busy     <= 1'b1;
                            r_clk_oe   <= 1'b1;
                            r_cnt      <= '0;
                            r_state    <= S_INHIBIT;
                        end
                    end
                    S_INHIBIT: begin
                        if (r_cnt == INH_LAST) begin
                            r_data_oe <= 1'b1;
                            r_cnt     <= '0;
                            r_state   <= S_REQ;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_REQ: begin
                        r_bit_cnt <= '0;
                        r_tcnt    <= '0;
                        if (r_cnt == REQ_LAST) begin
                            r_clk_oe <= 1'b0;
                            r_state  <= S_SEND;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    S_SEND: begin
                        r_tcnt <= r_tcnt + 1'b1;
                        if (w_fall) begin
                            r_data_oe <= ~frame_bit(r_byte, r_bit_cnt);
                            if (r_bit_cnt == 4'd9)
                                r_state <= S_ACK;
                            else
                                r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end
                    S_ACK: begin
                        r_tcnt <= r_tcnt + 1'b1;
                        if (w_fall) begin
                            r_nack_pend <= r_data_s2;
                            r_state     <= S_WAIT_IDLE;
                        end
                    end
                    S_WAIT_IDLE: begin
                        r_tcnt <= r_tcnt + 1'b1;
                        if (r_clk_s2 && r_data_s2) begin
                            r_done    <= 1'b1;
                            r_nack    <= r_nack_pend;
                            r_timeout <= 1'b0;
                            r_state   <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign tx_ready    = r_tx_ready;
    assign busy        = r_busy;
    assign ps2_clk_oe  = r_clk_oe;
    assign ps2_data_oe = r_data_oe;
    assign done        = r_done;
    assign nack        = r_nack;
    assign timeout     = r_timeout;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host over
// wired-AND lines; captured data_oe levels are compared with a frame model built from the byte.
module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TMO = 5000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       busy;
    logic       ps2_clk_i;
    logic       ps2_data_i;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       done;
    logic       nack;
    logic       timeout;

    logic dev_clk = 1'b1;
    logic dev_data = 1'b1;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    logic [7:0] acc_data[$];
    int         acc_cyc[$];

    assign ps2_clk_i  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_i = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .ps2_clk_i  (ps2_clk_i),
        .ps2_data_i (ps2_data_i),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .done       (done),
        .nack       (nack),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Host pulls data low for every 0 bit; the parity bit is 0 (pulled) when the byte has odd weight.
    function automatic logic [9:0] exp_oe(input logic [7:0] b);
        logic [9:0] e;
        int ones;
        ones = $countones(b);
        for (int i = 0; i < 8; i++) e[i] = (b[i] == 1'b0);
        e[8] = ((ones % 2) != 0);
        e[9] = 1'b0;
        return e;
    endfunction

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic handshake(input logic [7:0] b, output int t, output bit ok);
        int n;
        n = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = (tx_ready === 1'b1);
        t  = cyc;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Device side: waits for clock release, then generates nclk clock pulses,
    // capturing the host's data_oe mid-low-phase of clocks 1..10; ack pulls data on clock 11.
    task automatic dev_frame(input int half, input int nclk, input bit ack,
                             output logic [9:0] seen, output bit ok);
        int n;
        seen = '0;
        n = 0;
        while (ps2_clk_oe !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        ok = (ps2_clk_oe === 1'b0);
        repeat (half) @(negedge clk);
        for (int k = 1; k <= nclk; k++) begin
            if (k == 11 && ack) begin
                dev_data = 1'b0;
                repeat (5) @(negedge clk);
            end
            dev_clk = 1'b0;
            repeat (10) @(negedge clk);
            if (k <= 10) seen[k-1] = ps2_data_oe;
            repeat (half - 10) @(negedge clk);
            dev_clk = 1'b1;
            if (k == 11) dev_data = 1'b1;
            else repeat (half) @(negedge clk);
        end
    endtask

    task automatic wait_done(input int max, output int at, output bit got);
        int n;
        n = 0;
        while (done !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        got = (done === 1'b1);
        at  = cyc;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_vec++;
        if ({tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, nack, timeout} !== 7'b1000000) begin
            n_err++;
            $display("FAIL reset_hold: got %b want 1000000",
                     {tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, nack, timeout});
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, nack, timeout} !== 7'b1000000) begin
            n_err++;
            $display("FAIL reset_release: got %b want 1000000",
                     {tx_ready, busy, ps2_clk_oe, ps2_data_oe, done, nack, timeout});
        end
    endtask

    task automatic test_ack_f4();
        int t, td;
        bit ok, got;
        logic [9:0] seen;
        handshake(8'hF4, t, ok);
        n_vec++;
        if (!ok || {tx_ready, busy, ps2_clk_oe, ps2_data_oe} !== 4'b0110) begin
            n_err++;
            $display("FAIL f4_accept: ok=%0d got %b want 0110", ok,
                     {tx_ready, busy, ps2_clk_oe, ps2_data_oe});
        end
        dev_frame(100, 11, 1'b1, seen, ok);
        n_vec++;
        if (!ok || seen !== 10'b0100001011) begin
            n_err++;
            $display("FAIL f4_pattern: ok=%0d got %b want %b", ok, seen, 10'b0100001011);
        end
        n_vec++;
        if (seen !== exp_oe(8'hF4)) begin
            n_err++;
            $display("FAIL f4_model: got %b want %b", seen, exp_oe(8'hF4));
        end
        wait_done(50, td, got);
        n_vec++;
        if (!got || {nack, timeout} !== 2'b00) begin
            n_err++;
            $display("FAIL f4_done: done=%0d nack/timeout got %b want 00", got, {nack, timeout});
        end
        @(negedge clk);
        n_vec++;
        if ({done, tx_ready, busy} !== 3'b010) begin
            n_err++;
            $display("FAIL f4_after_done: got %b want 010", {done, tx_ready, busy});
        end
    endtask

    task automatic test_nack_ff();
        int t, td;
        bit ok, got;
        logic [9:0] seen;
        handshake(8'hFF, t, ok);
        dev_frame(100, 11, 1'b0, seen, ok);
        n_vec++;
        if (!ok || seen !== 10'b0000000000) begin
            n_err++;
            $display("FAIL ff_pattern: ok=%0d got %b want 0000000000", ok, seen);
        end
        wait_done(50, td, got);
        n_vec++;
        if (!got || {nack, timeout} !== 2'b10) begin
            n_err++;
            $display("FAIL ff_nack: done=%0d nack/timeout got %b want 10", got, {nack, timeout});
        end
        repeat (20) @(negedge clk);
        n_vec++;
        if ({done, nack, timeout} !== 3'b010) begin
            n_err++;
            $display("FAIL ff_flag_hold: got %b want 010", {done, nack, timeout});
        end
    endtask

    task automatic test_timeout_00();
        int t;
        bit ok;
        handshake(8'h00, t, ok);
        n_vec++;
        if (!ok || {ps2_clk_oe, ps2_data_oe, tx_ready} !== 3'b100) begin
            n_err++;
            $display("FAIL to_start: ok=%0d got %b want 100", ok, {ps2_clk_oe, ps2_data_oe, tx_ready});
        end
        wait_cyc(t + INH);
        n_vec++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b10) begin
            n_err++;
            $display("FAIL to_inhibit_end: got %b want 10", {ps2_clk_oe, ps2_data_oe});
        end
        wait_cyc(t + INH + 1);
        n_vec++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b11) begin
            n_err++;
            $display("FAIL to_req_start: got %b want 11", {ps2_clk_oe, ps2_data_oe});
        end
        wait_cyc(t + 36);
        n_vec++;
        if (ps2_clk_oe !== 1'b1) begin
            n_err++;
            $display("FAIL to_clk_hold: got %b want 1", ps2_clk_oe);
        end
        wait_cyc(t + 37);
        n_vec++;
        if (ps2_clk_oe !== 1'b0) begin
            n_err++;
            $display("FAIL to_clk_release: got %b want 0", ps2_clk_oe);
        end
        wait_cyc(t + 37 + TMO - 1);
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL to_early: done got %b want 0", done);
        end
        @(negedge clk);
        n_vec++;
        if ({done, timeout, nack, ps2_clk_oe, ps2_data_oe} !== 5'b11000) begin
            n_err++;
            $display("FAIL to_done: got %b want 11000", {done, timeout, nack, ps2_clk_oe, ps2_data_oe});
        end
    endtask

    task automatic test_reset_abort();
        int t, td;
        bit ok, got;
        logic [9:0] seen;
        handshake(8'hF4, t, ok);
        dev_frame(100, 4, 1'b0, seen, ok);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if ({ps2_clk_oe, ps2_data_oe, tx_ready, busy, nack, timeout} !== 6'b001000) begin
            n_err++;
            $display("FAIL abort_async: got %b want 001000",
                     {ps2_clk_oe, ps2_data_oe, tx_ready, busy, nack, timeout});
        end
        @(negedge clk);
        rst = 1'b1;
        wait_done(300, td, got);
        n_vec++;
        if (got) begin
            n_err++;
            $display("FAIL abort_no_done: done got 1 want 0 at cycle %0d", td);
        end
        handshake(8'hF4, t, ok);
        dev_frame(100, 11, 1'b1, seen, ok);
        n_vec++;
        if (!ok || seen !== exp_oe(8'hF4)) begin
            n_err++;
            $display("FAIL abort_resend_pattern: got %b want %b", seen, exp_oe(8'hF4));
        end
        wait_done(50, td, got);
        n_vec++;
        if (!got || {nack, timeout} !== 2'b00) begin
            n_err++;
            $display("FAIL abort_resend_done: done=%0d got %b want 00", got, {nack, timeout});
        end
    endtask

    task automatic test_back_to_back();
        int td, n;
        bit ok, got;
        logic [9:0] seen;
        acc_data.delete();
        acc_cyc.delete();
        @(negedge clk);
        tx_valid = 1'b1;
        fork
            begin
                int guard;
                guard = 0;
                while (acc_cyc.size() < 2 && guard < 20000) begin
                    tx_data = 8'($urandom);
                    if (tx_ready === 1'b1) begin
                        acc_data.push_back(tx_data);
                        acc_cyc.push_back(cyc);
                    end
                    @(negedge clk);
                    guard++;
                end
                tx_valid = 1'b0;
            end
        join_none
        n = 0;
        while (acc_cyc.size() < 1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (acc_cyc.size() < 1) begin
            $display("FAIL b2b_first_accept: accepted 0 want 1");
            $fatal(1, "no acceptance");
        end
        dev_frame(100, 11, 1'b1, seen, ok);
        n_vec++;
        if (!ok || seen !== exp_oe(acc_data[0])) begin
            n_err++;
            $display("FAIL b2b_first_pattern: got %b want %b", seen, exp_oe(acc_data[0]));
        end
        wait_done(50, td, got);
        n_vec++;
        if (!got || acc_cyc.size() != 1) begin
            n_err++;
            $display("FAIL b2b_single_accept: done=%0d accepted %0d want 1", got, acc_cyc.size());
        end
        n = 0;
        while (acc_cyc.size() < 2 && n < 10) begin
            @(negedge clk);
            n++;
        end
        n_vec++;
        if (acc_cyc.size() < 2 || acc_cyc[1] != td + 1) begin
            n_err++;
            $display("FAIL b2b_second_accept: accepted %0d, cycle %0d want %0d", acc_cyc.size(),
                     (acc_cyc.size() < 2) ? -1 : acc_cyc[1], td + 1);
        end
        if (acc_cyc.size() >= 2) begin
            dev_frame(100, 11, 1'b1, seen, ok);
            n_vec++;
            if (!ok || seen !== exp_oe(acc_data[1])) begin
                n_err++;
                $display("FAIL b2b_second_pattern: got %b want %b", seen, exp_oe(acc_data[1]));
            end
            wait_done(50, td, got);
            n_vec++;
            if (!got || {nack, timeout} !== 2'b00) begin
                n_err++;
                $display("FAIL b2b_second_done: done=%0d got %b want 00", got, {nack, timeout});
            end
        end
        tx_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_idle_noise();
        int bad;
        bad = 0;
        tx_valid = 1'b0;
        for (int i = 0; i < 200; i++) begin
            dev_clk  = 1'($urandom);
            dev_data = 1'($urandom);
            @(negedge clk);
            if ({ps2_clk_oe, ps2_data_oe, busy, done, tx_ready} !== 5'b00001) bad++;
        end
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        repeat (5) @(negedge clk);
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL idle_noise: %0d bad idle cycles want 0", bad);
        end
    endtask

    task automatic test_random();
        int t, td, half;
        bit ok, got, ack;
        logic [7:0] b;
        logic [9:0] seen;
        for (int i = 0; i < 4; i++) begin
            b    = 8'($urandom);
            ack  = 1'($urandom);
            half = $urandom_range(40, 120);
            handshake(b, t, ok);
            dev_frame(half, 11, ack, seen, ok);
            n_vec++;
            if (!ok || seen !== exp_oe(b)) begin
                n_err++;
                $display("FAIL rand_pattern[%0d] byte %h: got %b want %b", i, b, seen, exp_oe(b));
            end
            wait_done(50, td, got);
            n_vec++;
            if (!got || {nack, timeout} !== {~ack, 1'b0}) begin
                n_err++;
                $display("FAIL rand_flags[%0d]: done=%0d got %b want %b", i, got,
                         {nack, timeout}, {~ack, 1'b0});
            end
            repeat ($urandom_range(1, 5)) @(negedge clk);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ack_f4();
        test_nack_ff();
        test_timeout_00();
        test_reset_abort();
        test_back_to_back();
        test_idle_noise();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
